// File: rtl/dmio_pkg.sv
// Shared definitions for the DMIO arbiter: FSM state encoding, requester IDs
// and the IO-select address bit that the downstream decoder uses.
package dmio_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam logic REQ_C = 1'b0;
  localparam logic REQ_L = 1'b1;

  localparam int IO_BIT = 12;

endpackage

// File: rtl/dmio_rr_pick.sv
// Combinational winner select for the two DMIO requesters: round-robin on a
// tie, with the loader owning the port outright while the lock is held.
module dmio_rr_pick
  import dmio_pkg::*;
(
  input  logic c_req_i,
  input  logic l_req_i,
  input  logic last_grant_i,
  input  logic locked_i,
  output logic grant_o,
  output logic winner_o
);

  always_comb begin
    grant_o  = 1'b0;
    winner_o = REQ_C;
    // A held lock parks C even when L is momentarily idle.
    if (locked_i) begin
      grant_o  = l_req_i;
      winner_o = REQ_L;
    end else if (c_req_i && l_req_i) begin
      grant_o  = 1'b1;
      winner_o = ~last_grant_i;
    end else if (c_req_i) begin
      grant_o  = 1'b1;
      winner_o = REQ_C;
    end else if (l_req_i) begin
      grant_o  = 1'b1;
      winner_o = REQ_L;
    end
  end

endmodule

// File: rtl/dmio_arbiter.sv
// Two-requester arbiter/sequencer in front of the single-port DMIO block.
// Each granted transaction runs IDLE -> ACCESS -> DONE and is acked in DONE.
module dmio_arbiter
  import dmio_pkg::*;
#(
  parameter int DW       = 64,
  parameter int AW       = 64,
  parameter int LOCK_MAX = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_ack,
  input  logic          l_req,
  input  logic          l_we,
  input  logic [AW-1:0] l_addr,
  input  logic [DW-1:0] l_wdata,
  input  logic          l_lock,
  output logic          l_ack,
  output logic [DW-1:0] rd_data,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_data_write,
  output logic          mem_enable_write,
  input  logic [DW-1:0] mem_data_read,
  output logic          busy
);

  localparam int CW = $clog2(LOCK_MAX + 1);

  state_e          state_q, state_d;
  logic            winner_q, winner_d;
  logic            last_q, last_d;
  logic            locked_q, locked_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW-1:0]   rdata_q, rdata_d;

  logic            force_rel;
  logic            pick_grant;
  logic            pick_winner;

  // Once L has starved a waiting C for LOCK_MAX transactions the lock is dropped.
  assign force_rel = locked_q && (cnt_q >= CW'(LOCK_MAX)) && c_req;

  dmio_rr_pick u_pick (
    .c_req_i      (c_req),
    .l_req_i      (l_req),
    .last_grant_i (last_q),
    .locked_i     (locked_q && !force_rel),
    .grant_o      (pick_grant),
    .winner_o     (pick_winner)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      winner_q <= REQ_C;
      last_q   <= REQ_L;
      locked_q <= 1'b0;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      last_q   <= last_d;
      locked_q <= locked_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    last_d   = last_q;
    locked_d = locked_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    case (state_q)
      IDLE: begin
        if (force_rel) begin
          locked_d = 1'b0;
          cnt_d    = '0;
        end
        if (pick_grant) begin
          winner_d = pick_winner;
          last_d   = pick_winner;
          addr_d   = (pick_winner == REQ_L) ? l_addr  : c_addr;
          wdata_d  = (pick_winner == REQ_L) ? l_wdata : c_wdata;
          we_d     = (pick_winner == REQ_L) ? l_we    : c_we;
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        rdata_d = mem_data_read;
        // Only contended locked transactions count towards the release limit.
        if (winner_q == REQ_L) begin
          locked_d = l_lock;
          if (!l_lock) begin
            cnt_d = '0;
          end else if (c_req && (cnt_q < CW'(LOCK_MAX))) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign mem_address      = addr_q;
  assign mem_data_write   = wdata_q;
  assign mem_enable_write = (state_q == ACCESS) && we_q;
  assign c_ack            = (state_q == DONE) && (winner_q == REQ_C);
  assign l_ack            = (state_q == DONE) && (winner_q == REQ_L);
  assign rd_data          = rdata_q;
  assign busy             = (state_q != IDLE);

endmodule

// File: tb/tb_dmio_arbiter.sv
// Self-checking bench for dmio_arbiter: directed scenarios followed by random
// request traffic, predicted by a transaction-level arbitration model.
module tb_dmio_arbiter;

  localparam int DW       = 64;
  localparam int AW       = 64;
  localparam int LOCK_MAX = 16;
  localparam int WIN_C    = 0;
  localparam int WIN_L    = 1;
  localparam int WIN_NONE = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          cReq, cWe, lReq, lWe, lLock;
  logic [AW-1:0] cAddr, lAddr;
  logic [DW-1:0] cWdata, lWdata;
  logic          c_ack, l_ack, mem_enable_write, busy;
  logic [DW-1:0] rd_data, mem_data_write, mem_data_read;
  logic [AW-1:0] mem_address;

  int checks = 0;
  int errors = 0;

  // Reference model state, in arbitration-rule terms.
  int            lastG;
  bit            lockHeld;
  int            starveRun;
  logic [DW-1:0] refMem [256];
  int            lastWinner;

  int cPct, lPct, lockPct, wePct;

  // Environment memory: seeded contents overlaid with whatever the DUT writes.
  bit [DW-1:0] memArr   [256];
  bit          memValid [256];

  always #5 clk = ~clk;

  dmio_arbiter #(.DW(DW), .AW(AW), .LOCK_MAX(LOCK_MAX)) dut (
    .clk              (clk),
    .rst              (rst),
    .c_req            (cReq),
    .c_we             (cWe),
    .c_addr           (cAddr),
    .c_wdata          (cWdata),
    .c_ack            (c_ack),
    .l_req            (lReq),
    .l_we             (lWe),
    .l_addr           (lAddr),
    .l_wdata          (lWdata),
    .l_lock           (lLock),
    .l_ack            (l_ack),
    .rd_data          (rd_data),
    .mem_address      (mem_address),
    .mem_data_write   (mem_data_write),
    .mem_enable_write (mem_enable_write),
    .mem_data_read    (mem_data_read),
    .busy             (busy)
  );

  function automatic int idxOf(input logic [AW-1:0] a);
    return int'({a[12], a[9:3]});
  endfunction

  function automatic logic [DW-1:0] seedVal(input int i);
    if (i == 1) return 64'hDEAD;
    return {32'hA5A50000 + 32'(i), 32'(i) * 32'h9E3779B1};
  endfunction

  function automatic logic [AW-1:0] randAddr();
    logic [AW-1:0] a;
    a       = '0;
    a[12]   = 1'($urandom_range(1));
    a[9:3]  = 7'($urandom);
    return a;
  endfunction

  assign mem_data_read = memValid[idxOf(mem_address)] ? memArr[idxOf(mem_address)]
                                                      : seedVal(idxOf(mem_address));

  always @(posedge clk) begin
    if (mem_enable_write) begin
      memArr[idxOf(mem_address)]   <= mem_data_write;
      memValid[idxOf(mem_address)] <= 1'b1;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    lastG     = WIN_L;
    lockHeld  = 1'b0;
    starveRun = 0;
  endtask

  task automatic newC();
    cReq   = ($urandom_range(99) < cPct);
    cWe    = ($urandom_range(99) < wePct);
    cAddr  = randAddr();
    cWdata = {$urandom, $urandom};
  endtask

  task automatic newL();
    lReq   = ($urandom_range(99) < lPct);
    lWe    = ($urandom_range(99) < wePct);
    lAddr  = randAddr();
    lWdata = {$urandom, $urandom};
    lLock  = ($urandom_range(99) < lockPct);
  endtask

  // Winner of the finished transaction starts afresh; a pending loser holds.
  task automatic refresh(input int win);
    if (win == WIN_C || !cReq) newC();
    if (win == WIN_L || !lReq) newL();
  endtask

  task automatic doReset();
    rst  = 1'b1;
    cReq = 1'b0;
    lReq = 1'b0;
    lLock = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstAcks", {c_ack, l_ack}, 0);
    checkOutput("rstAddr", mem_address, 0);
    checkOutput("rstWdata", mem_data_write, 0);
    checkOutput("rstWe", mem_enable_write, 0);
    checkOutput("rstRd", rd_data, 0);
    rst = 1'b0;
    modelReset();
  endtask

  // One arbitration opportunity starting from IDLE, ending back in IDLE.
  task automatic applyStimulus();
    int            win;
    logic [AW-1:0] eAddr;
    logic [DW-1:0] eWdata;
    logic          eWe;
    if (lockHeld && starveRun >= LOCK_MAX && cReq) begin
      lockHeld  = 1'b0;
      starveRun = 0;
    end
    if (lockHeld)             win = lReq ? WIN_L : WIN_NONE;
    else if (cReq && lReq)    win = (lastG == WIN_C) ? WIN_L : WIN_C;
    else if (cReq)            win = WIN_C;
    else if (lReq)            win = WIN_L;
    else                      win = WIN_NONE;
    lastWinner = win;
    @(posedge clk);
    @(negedge clk);
    if (win == WIN_NONE) begin
      checkOutput("idleBusy", busy, 0);
      checkOutput("idleAck", {c_ack, l_ack}, 0);
      checkOutput("idleWe", mem_enable_write, 0);
      refresh(WIN_NONE);
      return;
    end
    eAddr  = (win == WIN_L) ? lAddr  : cAddr;
    eWdata = (win == WIN_L) ? lWdata : cWdata;
    eWe    = (win == WIN_L) ? lWe    : cWe;
    lastG  = win;
    if (win == WIN_L) begin
      lockHeld = lLock;
      if (!lLock) starveRun = 0;
      else if (cReq && starveRun < LOCK_MAX) starveRun++;
    end
    checkOutput("accBusy", busy, 1);
    checkOutput("accAddr", mem_address, eAddr);
    checkOutput("accWe", mem_enable_write, eWe);
    if (eWe) checkOutput("accWdata", mem_data_write, eWdata);
    checkOutput("accAck", {c_ack, l_ack}, 0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("doneAck", {c_ack, l_ack}, (win == WIN_L) ? 2'b01 : 2'b10);
    checkOutput("doneWe", mem_enable_write, 0);
    if (!eWe) checkOutput("rdData", rd_data, refMem[idxOf(eAddr)]);
    else      refMem[idxOf(eAddr)] = eWdata;
    refresh(win);
    @(posedge clk);
    @(negedge clk);
    checkOutput("postAck", {c_ack, l_ack}, 0);
    checkOutput("postBusy", busy, 0);
  endtask

  initial begin
    int burst;
    for (int i = 0; i < 256; i++) refMem[i] = seedVal(i);
    cWe = 0; lWe = 0; cAddr = '0; lAddr = '0; cWdata = '0; lWdata = '0;
    cPct = 0; lPct = 0; lockPct = 0; wePct = 50;
    doReset();

    // C read of preloaded word, then L write followed by C read-back.
    cReq = 1; cWe = 0; cAddr = 64'h8;
    applyStimulus();
    checkOutput("firstWinner", lastWinner, WIN_C);
    checkOutput("deadRead", rd_data, 64'hDEAD);
    lReq = 1; lWe = 1; lAddr = 64'h10; lWdata = 64'h1234; lLock = 0;
    applyStimulus();
    cReq = 1; cWe = 0; cAddr = 64'h10;
    applyStimulus();
    checkOutput("readBack", rd_data, 64'h1234);

    // IO-range address passes through untouched.
    lReq = 1; lWe = 1; lAddr = 64'h1000; lWdata = 64'hAA; lLock = 0;
    applyStimulus();
    cReq = 1; cWe = 0; cAddr = 64'h1000;
    applyStimulus();
    checkOutput("ioRead", rd_data, 64'hAA);

    // Continuous contention alternates starting with C.
    doReset();
    cPct = 100; lPct = 100; lockPct = 0;
    newC(); newL();
    for (int i = 0; i < 4; i++) begin
      applyStimulus();
      checkOutput("rrOrder", lastWinner, (i % 2 == 0) ? WIN_C : WIN_L);
    end

    // Locked L burst against a waiting C is cut after LOCK_MAX transactions.
    doReset();
    cPct = 100; lPct = 100; lockPct = 100;
    cReq = 1; cWe = 0; cAddr = 64'h20; lReq = 0;
    applyStimulus();
    burst = 0;
    for (int i = 0; i < 40; i++) begin
      applyStimulus();
      if (lastWinner != WIN_L) break;
      burst++;
    end
    checkOutput("lockBurst", burst, LOCK_MAX);
    checkOutput("lockRelease", lastWinner, WIN_C);

    // Uncontended lock keeps L, then blocks C while L is idle.
    doReset();
    cPct = 0; lPct = 100; lockPct = 100;
    lReq = 1; lWe = 0; lAddr = 64'h30; lLock = 1;
    for (int i = 0; i < 20; i++) begin
      if (i == 19) lPct = 0;
      applyStimulus();
      checkOutput("lockKeep", lastWinner, WIN_L);
    end
    cPct = 100;
    cReq = 1; cWe = 0; cAddr = 64'h38;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput("lockBlock", lastWinner, WIN_NONE);
    end

    // Reset in the middle of a C write aborts it without an ack.
    doReset();
    cPct = 0; lPct = 0; lockPct = 0;
    cReq = 1; cWe = 1; cAddr = 64'h18; cWdata = 64'hBAD; lReq = 0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("preRstWe", mem_enable_write, 1);
    rst = 1'b1;
    #1;
    checkOutput("abortWe", mem_enable_write, 0);
    checkOutput("abortAddr", mem_address, 0);
    checkOutput("abortWdata", mem_data_write, 0);
    checkOutput("abortBusy", busy, 0);
    checkOutput("abortAck", {c_ack, l_ack}, 0);
    checkOutput("abortRd", rd_data, 0);
    cReq = 0;
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    @(posedge clk);
    @(negedge clk);
    checkOutput("abortNoAck", {c_ack, l_ack}, 0);
    cReq = 1; cWe = 0; cAddr = 64'h18;
    lReq = 1; lWe = 0; lAddr = 64'h40; lLock = 0;
    applyStimulus();
    checkOutput("postRstWinner", lastWinner, WIN_C);

    // Random traffic with shifting request/lock densities.
    for (int i = 0; i < 300; i++) begin
      if (i % 25 == 0) begin
        cPct    = $urandom_range(100);
        lPct    = $urandom_range(100);
        lockPct = $urandom_range(100);
        wePct   = 50;
      end
      applyStimulus();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
